// File: rtl/rram_seq_pkg.sv
// rram_seq_pkg: state encoding, layer bit masks and timer width for the RRAM training sequencer.
package rram_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, INIT, WAIT_IN, FWD_L1, FWD_L2, FWD_L3, ERR, BACK, UPD_L3, UPD_L2, UPD_L1, DONE
  } state_t;
  localparam logic [5:0] L1_M = 6'b110000;
  localparam logic [5:0] L2_M = 6'b001100;
  localparam logic [5:0] L3_M = 6'b000010;
  localparam int TW = 16;
endpackage

// File: rtl/rram_phase_timer.sv
// rram_phase_timer: loadable down-counter; expired is high once the loaded count has run out.
module rram_phase_timer
  import rram_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] val,
  output logic          expired
);
  logic [TW-1:0] cnt;
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/rram_train_sequencer.sv
// rram_train_sequencer: drives RRAM crossbar controls through forward/error/backward/update phases per sample.
// Optional RRAM_SEQ_INFER_EN adds infer_mode: a sample latched with it set skips ERR/BACK/UPD.
module rram_train_sequencer
  import rram_seq_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int PULSE_CYC  = 2,
  parameter int INIT_CYC   = 3,
  parameter int N_SAMPLES  = 4,
  parameter int N_EPOCHS   = 16,
  localparam int SW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1,
  localparam int EW = N_EPOCHS > 1 ? $clog2(N_EPOCHS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_x,
  input  logic          in_label,
`ifdef RRAM_SEQ_INFER_EN
  input  logic          infer_mode,
`endif
  output logic [5:0]    Dwl,
  output logic [5:0]    Dsl,
  output logic [5:0]    Dbl,
  output logic          Dset,
  output logic          Dback,
  output logic          Dlabel,
  output logic [3:0]    phase,
  output logic [SW-1:0] sample_cnt,
  output logic [EW-1:0] epoch_cnt,
  output logic          busy,
  output logic          done
);
  state_t st, ns;
  logic [1:0] x_lat, nx;
  logic lab_lat, inf_lat, inf_in, hs, exp_t, last_s, last_e, fin, adv;
  logic [TW-1:0] len;
  logic [5:0] wl_n, sl_n, bl_n;
`ifdef RRAM_SEQ_INFER_EN
  assign inf_in = infer_mode;
`else
  assign inf_in = 1'b0;
`endif
  assign in_ready = st == WAIT_IN;
  assign phase = st;
  assign hs = in_ready && in_valid;
  assign nx = hs ? in_x : x_lat;
  assign last_s = sample_cnt == SW'(N_SAMPLES - 1);
  assign last_e = epoch_cnt == EW'(N_EPOCHS - 1);
  assign fin = last_s && last_e;
  assign adv = exp_t && (st == UPD_L1 || (st == FWD_L3 && inf_lat));
  rram_phase_timer u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(ns != st),
    .val(len),
    .expired(exp_t)
  );
  always_comb begin
    ns = st;
    case (st)
      IDLE:    ns = start ? INIT : IDLE;
      INIT:    ns = exp_t ? WAIT_IN : INIT;
      WAIT_IN: ns = in_valid ? FWD_L1 : WAIT_IN;
      FWD_L1:  ns = exp_t ? FWD_L2 : FWD_L1;
      FWD_L2:  ns = exp_t ? FWD_L3 : FWD_L2;
      FWD_L3:  ns = !exp_t ? FWD_L3 : !inf_lat ? ERR : fin ? DONE : WAIT_IN;
      ERR:     ns = exp_t ? BACK : ERR;
      BACK:    ns = exp_t ? UPD_L3 : BACK;
      UPD_L3:  ns = exp_t ? UPD_L2 : UPD_L3;
      UPD_L2:  ns = exp_t ? UPD_L1 : UPD_L2;
      UPD_L1:  ns = !exp_t ? UPD_L1 : fin ? DONE : WAIT_IN;
      default: ns = IDLE;
    endcase
    if (abort) ns = IDLE;
  end
  always_comb begin
    len = ns == INIT ? TW'(INIT_CYC - 1)
        : ns inside {FWD_L1, FWD_L2, FWD_L3, ERR, BACK} ? TW'(SETTLE_CYC - 1)
        : ns inside {UPD_L3, UPD_L2, UPD_L1} ? TW'(PULSE_CYC - 1) : '0;
    wl_n = ns == FWD_L1 ? {nx, 4'b0000} : ns == FWD_L2 ? L2_M : ns == FWD_L3 ? L3_M : '0;
    sl_n = ns == FWD_L1 ? L1_M : ns == FWD_L2 ? L2_M : ns == FWD_L3 ? L3_M : '0;
    bl_n = ns == UPD_L1 ? L1_M : ns == UPD_L2 ? L2_M : ns == UPD_L3 ? L3_M : '0;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      st         <= IDLE;
      x_lat      <= '0;
      lab_lat    <= 1'b0;
      inf_lat    <= 1'b0;
      sample_cnt <= '0;
      epoch_cnt  <= '0;
      Dwl        <= '0;
      Dsl        <= '0;
      Dbl        <= '0;
      Dset       <= 1'b0;
      Dback      <= 1'b0;
      Dlabel     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      st <= ns;
      if (hs) begin
        x_lat   <= in_x;
        lab_lat <= in_label;
        inf_lat <= inf_in;
      end
      if (abort || st == DONE) begin
        sample_cnt <= '0;
        epoch_cnt  <= '0;
      end else if (adv) begin
        sample_cnt <= last_s ? '0 : sample_cnt + 1'b1;
        if (last_s) epoch_cnt <= last_e ? '0 : epoch_cnt + 1'b1;
      end
      Dwl    <= wl_n;
      Dsl    <= sl_n;
      Dbl    <= bl_n;
      Dset   <= ns == INIT;
      Dback  <= ns inside {BACK, UPD_L3, UPD_L2, UPD_L1};
      Dlabel <= lab_lat && (ns inside {ERR, BACK, UPD_L3, UPD_L2, UPD_L1});
      busy   <= ns != IDLE;
      done   <= ns == DONE;
    end
endmodule

// File: doc/rram_train_sequencer.md
Name: rram_train_sequencer

Overview:
Digital sequencer that sits directly upstream of the RRAM crossbar unit and generates every control input it consumes: Dwl/Dsl/Dbl per layer, Dset, Dback and Dlabel. It accepts training samples over a valid/ready handshake. Each sample is stepped through forward, error, backward and per-layer update phases with programmable settle and pulse widths, for a fixed number of samples and epochs.

Parameters:
SETTLE_CYC, 4, cycles each forward/error/backward phase is held (min 1)
PULSE_CYC, 2, cycles each per-layer update pulse is held (min 1)
INIT_CYC, 3, cycles Dset is held after start (min 1)
N_SAMPLES, 4, samples per epoch (min 1)
N_EPOCHS, 16, epochs per run (min 1)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
abort  in  1  synchronous abort; forces IDLE next edge
in_valid  in  1  sample valid
in_ready  out  1  sequencer can accept a sample (WAIT_IN only)
in_x  in  2  layer-1 input pattern, drives Dwl[5:4] in FWD_L1
in_label  in  1  target label for the sample
Dwl  out  6  word-line enables, bits 5:4 L1, 3:2 L2, 1 L3, 0 tied 0
Dsl  out  6  source-line enables, same bit map
Dbl  out  6  bit-line (update) enables, same bit map
Dset  out  1  array set/init strobe
Dback  out  1  backward-propagation enable
Dlabel  out  1  latched label to error calculator
phase  out  4  current state encoding (package enum)
sample_cnt  out  $clog2(N_SAMPLES)  sample index within epoch
epoch_cnt  out  $clog2(N_EPOCHS)  current epoch
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on run completion

Behaviour:
- One clock domain. rst_n is synchronous and active-low. Reset: state IDLE; all D* outputs, in_ready, busy, done at 0; counters at 0; latched x/label at 0.
- The phase counter loads the state length on entry and the state exits when the counter expires. A state of length L is active for exactly L cycles.
- IDLE: start=1 -> INIT. Outputs all 0.
- INIT: Dset=1 for INIT_CYC cycles -> WAIT_IN.
- WAIT_IN: in_ready=1. On in_valid&&in_ready, in_x and in_label are latched and the state moves to FWD_L1 on the same edge.
- FWD_L1, SETTLE_CYC cycles: Dwl[5:4]=x_lat, Dsl[5:4]=2'b11.
- FWD_L2, SETTLE_CYC cycles: Dwl[3:2]=2'b11, Dsl[3:2]=2'b11.
- FWD_L3, SETTLE_CYC cycles: Dwl[1]=1, Dsl[1]=1.
- ERR, SETTLE_CYC cycles: Dlabel=label_lat.
- BACK, SETTLE_CYC cycles: Dback=1. Dlabel stays held.
- UPD_L3, UPD_L2, UPD_L1, PULSE_CYC each:
  - Dback=1 and Dlabel held throughout.
  - Dbl asserted on the layer's bits only: [1], [3:2], [5:4] respectively.
- End of UPD_L1:
  - sample_cnt increments; it wraps to 0 at N_SAMPLES-1 and epoch_cnt increments.
  - If the last sample of the last epoch has finished: -> DONE. Otherwise -> WAIT_IN.
- DONE: done=1 for one cycle, counters clear -> IDLE.
- Per-sample active length is 5*SETTLE_CYC + 3*PULSE_CYC cycles; in_ready is low for exactly that long.
- Only one layer's D* bits are nonzero in any cycle; Dwl[0], Dsl[0], Dbl[0] are always 0.
- All outputs are registered. There is no combinational path from inputs to outputs except in_ready, which is a state decode.
- abort has priority over every transition: next edge goes to IDLE with all outputs 0, counters cleared, and done not asserted.
- rst_n has priority over abort.
- start outside IDLE is ignored. in_valid outside WAIT_IN is ignored and the data is not consumed.

Optional Feature:
RRAM_SEQ_INFER_EN:
- Defined: adds input port infer_mode (1 bit), sampled at the handshake.
  - If set, FWD_L3 -> WAIT_IN, skipping ERR/BACK/UPD.
  - Counters advance as normal. Dback and Dbl never assert for that sample.
- Undefined: port absent; every sample trains.

Decomposition:
- Package rram_seq_pkg: state enum (IDLE, INIT, WAIT_IN, FWD_L1..3, ERR, BACK, UPD_L3..1, DONE, 4-bit), layer bit-mask constants (L1=6'b110000, L2=6'b001100, L3=6'b000010).
- Sub-module rram_phase_timer: loadable down-counter with an expire flag, used by every timed state.

Test Plan:
- Defaults, start then one sample x=2'b10, label=1 -> Dset high for 3 cycles; Dwl=6'b100000 for 4 cycles; Dlabel=1 from ERR through UPD_L1; in_ready low for exactly 26 cycles.
- Full run with in_valid held at 1 -> 64 handshakes, done pulses exactly once, epoch_cnt wraps 15->0, busy falls the cycle after done.
- in_valid pulsed during FWD_L2 -> not consumed; in_x change is ignored and Dwl[5:4] keeps the latched value.
- abort asserted in BACK -> next cycle all D* 0, phase=IDLE, counters 0, no done pulse.
- rst_n low in UPD_L2 together with abort -> reset values next edge; start afterwards re-runs INIT.
- With RRAM_SEQ_INFER_EN and infer_mode=1 -> 12-cycle sample, Dback and Dbl stay 0 for that sample, sample_cnt increments.
